// File: rtl/tqvp_bus_initiator.sv
// tqvp_bus_initiator
// Initiator side of the TinyQV peripheral bus. It takes one command at a time
// from a valid/ready port and issues a single 8/16/32-bit read or write. It
// then returns the read data and a status code on a second valid/ready port.
// A read that is not acknowledged within TIMEOUT strobe cycles is abandoned.
// An illegal size code is answered directly and never reaches the bus.

module tqvp_bus_initiator #(
  parameter int unsigned TIMEOUT = 16  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst_n,

  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,

  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,

  output logic        busy,

  // TinyQV peripheral bus
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  output logic [1:0]  bus_read_n,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] STROBE_IDLE  = 2'b11;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_ILLEGAL = 2'b10;

  // The last wait count before a read is abandoned. The strobe therefore
  // lasts at most TIMEOUT cycles.
  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg,       state_next;
  logic [1:0]  size_reg,        size_next;
  logic [7:0]  count_reg,       count_next;
  logic [5:0]  bus_address_reg, bus_address_next;
  logic [31:0] bus_wdata_reg,   bus_wdata_next;
  logic [1:0]  bus_write_n_reg, bus_write_n_next;
  logic [1:0]  bus_read_n_reg,  bus_read_n_next;
  logic        rsp_valid_reg,   rsp_valid_next;
  logic [31:0] rsp_rdata_reg,   rsp_rdata_next;
  logic [1:0]  rsp_status_reg,  rsp_status_next;

  // Read data trimmed to the access size. The upper bits are zero for 8/16-bit reads.
  logic [31:0] rdata_masked;

  // Zero-extend the captured read data according to the latched size.
  always_comb begin
    rdata_masked = bus_rdata;
    case (size_reg)
      2'b00:   rdata_masked = {24'd0, bus_rdata[7:0]};
      2'b01:   rdata_masked = {16'd0, bus_rdata[15:0]};
      default: rdata_masked = bus_rdata;
    endcase
  end

  // Next-state and next-output decode. Every register holds unless a transition changes it.
  always_comb begin
    state_next       = state_reg;
    size_next        = size_reg;
    count_next       = count_reg;
    bus_address_next = bus_address_reg;
    bus_wdata_next   = bus_wdata_reg;
    bus_write_n_next = bus_write_n_reg;
    bus_read_n_next  = bus_read_n_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_status_next  = rsp_status_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          // The bus address/data registers double as the command latch.
          bus_address_next = cmd_addr;
          bus_wdata_next   = cmd_wdata;
          size_next        = cmd_size;
          if (cmd_size == SIZE_ILLEGAL) begin
            // Answer directly. No strobe is driven for an illegal size.
            rsp_valid_next  = 1'b1;
            rsp_status_next = STATUS_ILLEGAL;
            rsp_rdata_next  = 32'd0;
            state_next      = ST_RESP;
          end else if (cmd_write) begin
            bus_write_n_next = cmd_size;
            state_next       = ST_WRITE;
          end else begin
            bus_read_n_next = cmd_size;
            count_next      = 8'd0;
            state_next      = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        // A write strobe lasts a single cycle. The peripheral's ready is not consulted.
        bus_write_n_next = STROBE_IDLE;
        rsp_valid_next   = 1'b1;
        rsp_status_next  = STATUS_OK;
        rsp_rdata_next   = 32'd0;
        state_next       = ST_RESP;
      end

      ST_READ: begin
        if (bus_ready) begin
          bus_read_n_next = STROBE_IDLE;
          rsp_valid_next  = 1'b1;
          rsp_status_next = STATUS_OK;
          rsp_rdata_next  = rdata_masked;
          state_next      = ST_RESP;
        end else begin
          count_next = count_reg + 8'd1;
          if (count_reg == COUNT_LAST) begin
            bus_read_n_next = STROBE_IDLE;
            rsp_valid_next  = 1'b1;
            rsp_status_next = STATUS_TIMEOUT;
            rsp_rdata_next  = 32'd0;
            state_next      = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        // The response stays on the port, unchanged, until it is taken.
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers. A reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      size_reg        <= 2'b00;
      count_reg       <= 8'd0;
      bus_address_reg <= 6'd0;
      bus_wdata_reg   <= 32'd0;
      bus_write_n_reg <= STROBE_IDLE;
      bus_read_n_reg  <= STROBE_IDLE;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= 32'd0;
      rsp_status_reg  <= STATUS_OK;
    end else begin
      state_reg       <= state_next;
      size_reg        <= size_next;
      count_reg       <= count_next;
      bus_address_reg <= bus_address_next;
      bus_wdata_reg   <= bus_wdata_next;
      bus_write_n_reg <= bus_write_n_next;
      bus_read_n_reg  <= bus_read_n_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_status_reg  <= rsp_status_next;
    end
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign bus_address = bus_address_reg;
  assign bus_wdata   = bus_wdata_reg;
  assign bus_write_n = bus_write_n_reg;
  assign bus_read_n  = bus_read_n_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_status  = rsp_status_reg;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Testbench for tqvp_bus_initiator.
// It applies a table of directed transactions, some hand-written reset
// sequences and a batch of random transactions. Expected results come from a
// transaction-level model: strobe length, latency, data and status.
`timescale 1ns/1ps

module tb_tqvp_bus_initiator;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [5:0]  bus_address;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_write_n, bus_read_n;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int checks = 0;
  int errors = 0;

  tqvp_bus_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .busy(busy),
    .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_write_n(bus_write_n), .bus_read_n(bus_read_n),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        write;
    bit [1:0]  size;
    bit [5:0]  addr;
    bit [31:0] wdata;
    bit [31:0] brdata;     // value the peripheral returns
    int        wait_cyc;   // strobe cycles with ready low before ready rises
    int        rsp_delay;  // cycles rsp_ready is held low after rsp_valid
    bit [31:0] exp_rdata;
    bit [1:0]  exp_status;
    int        exp_strobe; // strobe length in cycles (0 = none)
    int        exp_lat;    // negedges after the accept edge until rsp_valid seen
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome from size/direction/peripheral wait.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.size == 2'b11) begin
      r.exp_status = 2'b10; r.exp_rdata = 0; r.exp_strobe = 0; r.exp_lat = 1;
    end else if (v.write) begin
      r.exp_status = 2'b00; r.exp_rdata = 0; r.exp_strobe = 1; r.exp_lat = 2;
    end else if (v.wait_cyc < TO) begin
      r.exp_status = 2'b00;
      if (v.size == 2'b00)      r.exp_rdata = v.brdata % 256;
      else if (v.size == 2'b01) r.exp_rdata = v.brdata % 65536;
      else                      r.exp_rdata = v.brdata;
      r.exp_strobe = v.wait_cyc + 1;
      r.exp_lat    = v.wait_cyc + 2;
    end else begin
      r.exp_status = 2'b01; r.exp_rdata = 0; r.exp_strobe = TO; r.exp_lat = TO + 1;
    end
    return r;
  endfunction

  // Issue one command, act as the peripheral, then check the response and the handshake.
  task automatic apply(input vec_t v, input string tag);
    int wc, rc, lat;
    bit done;
    logic [31:0] r_data;
    logic [1:0]  r_stat;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_size = v.size;
    cmd_addr = v.addr; cmd_wdata = v.wdata;
    chk({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the command bus: the DUT must have latched it.
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_size = 2'($urandom);
    cmd_addr = 6'($urandom); cmd_wdata = $urandom;
    wc = 0; rc = 0; lat = 0; done = 1'b0;
    for (int n = 1; n <= 64 && !done; n++) begin
      if (n > 1) @(negedge clk);
      if (rsp_valid) begin
        lat = n; done = 1'b1;
      end else begin
        chk({tag, " strobe_exclusive"},
            32'((bus_write_n != 2'b11) && (bus_read_n != 2'b11)), 32'd0);
        if (bus_write_n != 2'b11) begin
          wc++;
          chk({tag, " wr_size"}, 32'(bus_write_n), 32'(v.size));
          chk({tag, " wr_addr"}, 32'(bus_address), 32'(v.addr));
          chk({tag, " wr_data"}, bus_wdata, v.wdata);
          bus_ready = 1'($urandom);
          bus_rdata = $urandom;
        end else if (bus_read_n != 2'b11) begin
          rc++;
          chk({tag, " rd_size"}, 32'(bus_read_n), 32'(v.size));
          chk({tag, " rd_addr"}, 32'(bus_address), 32'(v.addr));
          bus_ready = (rc - 1 == v.wait_cyc);
          bus_rdata = v.brdata;
        end else begin
          bus_ready = 1'b0;
          bus_rdata = $urandom;
        end
      end
    end
    bus_ready = 1'b0;
    chk({tag, " rsp_arrived"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " wr_strobe_len"}, 32'(wc), v.write ? 32'(v.exp_strobe) : 32'd0);
    chk({tag, " rd_strobe_len"}, 32'(rc), v.write ? 32'd0 : 32'(v.exp_strobe));
    chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " rsp_status"}, 32'(rsp_status), 32'(v.exp_status));
    chk({tag, " cmd_ready_resp"}, 32'(cmd_ready), 32'd0);
    chk({tag, " busy_resp"}, 32'(busy), 32'd1);
    r_data = rsp_rdata; r_stat = rsp_status;
    for (int d = 0; d < v.rsp_delay; d++) begin
      @(negedge clk);
      chk({tag, " rsp_held"}, 32'(rsp_valid), 32'd1);
      chk({tag, " rsp_stable"}, {r_data[29:0], r_stat} ^ {rsp_rdata[29:0], rsp_status}, 32'd0);
      chk({tag, " cmd_ready_wait"}, 32'(cmd_ready), 32'd0);
      chk({tag, " no_strobe_wait"}, 32'({bus_write_n, bus_read_n}), 32'hF);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " rsp_dropped"}, 32'(rsp_valid), 32'd0);
    chk({tag, " back_idle"}, 32'({cmd_ready, busy}), 32'b10);
    chk({tag, " addr_hold"}, 32'(bus_address), 32'(v.addr));
    chk({tag, " wdata_hold"}, bus_wdata, v.wdata);
    chk({tag, " strobes_idle"}, 32'({bus_write_n, bus_read_n}), 32'hF);
    $display("txn %s: write=%0d size=%0d addr=%h wdata=%h rdata=%h status=%0d strobe=%0d lat=%0d",
             tag, v.write, v.size, v.addr, v.wdata, r_data, r_stat, v.write ? wc : rc, lat);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    // write,size,addr,wdata,brdata,wait,rsp_delay, exp_rdata,exp_status,exp_strobe,exp_lat
    tbl[0] = '{1'b1, 2'b10, 6'h00, 32'h6000_0000, 32'h0, 0, 0, 32'h0, 2'b00, 1, 2};
    tbl[1] = '{1'b0, 2'b00, 6'h18, 32'h0, 32'hDEAD_BEA5, 0, 0, 32'h0000_00A5, 2'b00, 1, 2};
    tbl[2] = '{1'b0, 2'b01, 6'h04, 32'h0, 32'h1234_5678, 3, 1, 32'h0000_5678, 2'b00, 4, 5};
    tbl[3] = '{1'b0, 2'b10, 6'h08, 32'h0, 32'hCAFE_F00D, 100, 0, 32'h0, 2'b01, 16, 17};
    tbl[4] = '{1'b1, 2'b11, 6'h10, 32'hAAAA_5555, 32'h0, 0, 5, 32'h0, 2'b10, 0, 1};
    tbl[5] = '{1'b1, 2'b00, 6'h3F, 32'hFFFF_FFFF, 32'h0, 0, 2, 32'h0, 2'b00, 1, 2};
    tbl[6] = '{1'b0, 2'b10, 6'h21, 32'h0, 32'h8765_4321, 15, 0, 32'h8765_4321, 2'b00, 16, 17};
    tbl[7] = '{1'b0, 2'b00, 6'h2A, 32'h0, 32'h0000_0077, 16, 0, 32'h0, 2'b01, 16, 17};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00;
    cmd_addr = 6'd0; cmd_wdata = 32'd0; rsp_ready = 1'b0;
    bus_rdata = 32'd0; bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset strobes", 32'({bus_write_n, bus_read_n}), 32'hF);
    chk("reset addr", 32'(bus_address), 32'd0);
    chk("reset wdata", bus_wdata, 32'd0);
    chk("reset rsp", 32'({rsp_valid, rsp_status}), 32'd0);
    chk("reset rdata", rsp_rdata, 32'd0);
    chk("reset ready_busy", 32'({cmd_ready, busy}), 32'b10);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Reset during the second wait cycle of a read aborts it silently.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b01; cmd_addr = 6'h11;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_abort first_wait", 32'(bus_read_n), 32'b01);
    @(negedge clk);
    chk("rst_abort second_wait", 32'(bus_read_n), 32'b01);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_abort strobes", 32'({bus_write_n, bus_read_n}), 32'hF);
    chk("rst_abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_abort cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_abort quiet", 32'({rsp_valid, bus_write_n, bus_read_n}), 32'hF);
    end
    $display("txn rst_abort: read aborted by reset");
    apply(tbl[0], "post_reset_write");

    // Random transactions checked against the model.
    for (int i = 0; i < 40; i++) begin
      rv = '{default: 0};
      rv.write     = 1'($urandom);
      rv.size      = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
      rv.addr      = 6'($urandom);
      rv.wdata     = $urandom;
      rv.brdata    = $urandom;
      rv.wait_cyc  = $urandom_range(0, 20);
      rv.rsp_delay = $urandom_range(0, 3);
      rv = model(rv);
      apply(rv, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tqvp_bus_initiator.md
Name: tqvp_bus_initiator

Overview:
- Drives the TinyQV peripheral bus (address / write data / data_write_n / data_read_n / data_ready / read data) as the initiator side.
- Accepts one command at a time on a valid/ready port and issues a single 8/16/32-bit read or write.
- Returns a response with read data and a status code on a second valid/ready port.
- Used as a bench/bridge master for peripherals such as the PRISM block, e.g. behind a UART or debug controller.

Parameters:
- TIMEOUT, 16, max cycles a read stays asserted waiting for bus_ready (legal 1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_size  in  2  00=8b, 01=16b, 10=32b, 11=illegal
- cmd_addr  in  6  peripheral address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  32  read data, zero-extended per size; 0 for writes and errors
- rsp_status  out  2  00=ok, 01=timeout, 10=illegal size
- busy  out  1  state != IDLE
- bus_address  out  6  to peripheral address
- bus_wdata  out  32  to peripheral data_in
- bus_write_n  out  2  11=idle, else size code
- bus_read_n  out  2  11=idle, else size code
- bus_rdata  in  32  from peripheral data_out
- bus_ready  in  1  from peripheral data_ready

Behaviour:
- All outputs are registered, except cmd_ready and busy, which decode state.
- Reset (rst_n low at a clk edge):
  - state=IDLE
  - bus_write_n=bus_read_n=11
  - bus_address=0, bus_wdata=0
  - rsp_valid=0, rsp_rdata=0, rsp_status=00
  - timeout counter=0
- Reset mid-transaction aborts it at that edge. No response is produced and no further strobe is driven.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr, wdata, size and write; load bus_address/bus_wdata from the command.
  - size=11 -> RESP with status=10, rdata=0. No bus strobe is ever driven.
  - write -> WRITE; bus_write_n=size from the next cycle.
  - read -> READ; bus_read_n=size from the next cycle; counter=0.
- WRITE:
  - Exactly one cycle with bus_write_n=size; bus_ready is ignored.
  - Next edge: bus_write_n=11, go to RESP with status=00, rdata=0.
- READ:
  - bus_read_n=size held every cycle in this state.
  - bus_ready high: capture bus_rdata masked to [7:0] (8b) or [15:0] (16b), upper bits zero; 32b is unmasked.
    - Same edge: bus_read_n=11, go to RESP with status=00.
  - bus_ready low: counter+1.
    - If counter==TIMEOUT-1 at that edge: bus_read_n=11, RESP, status=01, rdata=0.
    - Maximum strobe length is therefore TIMEOUT cycles.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_status are stable until the handshake.
  - cmd_ready=0.
  - On rsp_ready: next edge rsp_valid=0 and go to IDLE.
  - No response is ever dropped or overwritten.
- Latency with rsp_ready tied high:
  - write and zero-wait read: rsp_valid 2 cycles after the accept edge.
  - illegal size: rsp_valid 1 cycle after the accept edge.
- Back-to-back commands: at most one transaction every 3 cycles. bus_write_n/bus_read_n always return to 11 for at least one cycle between transactions.
- bus_address and bus_wdata hold their last values while IDLE.
- bus_write_n and bus_read_n are never both non-11.

Test Plan:
- Write addr=0x00, wdata=0x6000_0000, size=10:
  - bus_write_n=10 for exactly 1 cycle with bus_address=0x00 and bus_wdata=0x6000_0000.
  - Then rsp_valid, status=00, rdata=0.
- Read addr=0x18, size=00, bus_rdata=0xDEAD_BEA5, bus_ready=1:
  - bus_read_n=00 for 1 cycle.
  - rsp_rdata=0x0000_00A5, status=00; rsp_valid 2 cycles after accept.
- Read size=01 with bus_ready low for 3 cycles, then high with bus_rdata=0x1234_5678:
  - Strobe lasts 4 cycles.
  - rsp_rdata=0x0000_5678, status=00.
- Read with bus_ready stuck low, TIMEOUT=16:
  - bus_read_n=10 for exactly 16 cycles, then 11.
  - rsp_status=01, rsp_rdata=0.
- cmd_size=11, then rsp_ready held low for 5 cycles:
  - No bus strobe.
  - rsp_valid held with status=10.
  - cmd_ready=0 while rsp_ready is low; IDLE one edge after rsp_ready.
- rst_n low for 1 cycle during the 2nd wait cycle of a read:
  - Next cycle bus_read_n=11, rsp_valid=0, cmd_ready=1.
  - A subsequent write completes normally.
